// File: rtl/stopwatch_fnd_scan_pkg.sv
// Shared constants for the stopwatch FND scanner: 7-segment codes, segment bit order
// and the scan FSM state type.
package stopwatch_fnd_scan_pkg;

  localparam int NUM_DIGITS_DEF = 6;

  // Segment vector bit positions within {dp,g,f,e,d,c,b,a}
  localparam int SEG_BIT_A  = 0;
  localparam int SEG_BIT_G  = 6;
  localparam int SEG_BIT_DP = 7;

  // Active-high {g,f,e,d,c,b,a} patterns
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_ERR = 7'h40;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

endpackage

// File: rtl/stopwatch_fnd_scan_if.sv
// Digit-in / FND-pins-out bundle between the stopwatch counter, the scanner and the board.
interface stopwatch_fnd_scan_if
  import stopwatch_fnd_scan_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
);

  logic [4*NUM_DIGITS-1:0] iDigits;
  logic [NUM_DIGITS-1:0]   iDpMask;
  logic                    iBlank;
  logic [7:0]              oSeg;
  logic [NUM_DIGITS-1:0]   oCom;
  logic                    oFrameStart;

  modport master (
    output iDigits, iDpMask, iBlank,
    input  oSeg, oCom, oFrameStart
  );

  modport slave (
    input  iDigits, iDpMask, iBlank,
    output oSeg, oCom, oFrameStart
  );

endinterface

// File: rtl/stopwatch_fnd_scan_decode.sv
// BCD nibble plus decimal point to active-high {dp,g,f,e,d,c,b,a}; non-decimal nibbles
// show a lone g segment as an error mark.
module stopwatch_fnd_scan_decode
  import stopwatch_fnd_scan_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = '0;
    case (nib)
      4'd0:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_0;
      4'd1:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_1;
      4'd2:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_2;
      4'd3:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_3;
      4'd4:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_4;
      4'd5:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_5;
      4'd6:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_6;
      4'd7:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_7;
      4'd8:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_8;
      4'd9:    seg[SEG_BIT_G:SEG_BIT_A] = SEG_9;
      default: seg[SEG_BIT_G:SEG_BIT_A] = SEG_ERR;
    endcase
    seg[SEG_BIT_DP] = dp;
  end

endmodule

// File: rtl/stopwatch_fnd_scan.sv
// Multiplexed 7-segment scanner: per-digit slots with a dark guard gap, one digit
// snapshot per frame, optional leading-zero blanking, fully registered pins.
module stopwatch_fnd_scan
  import stopwatch_fnd_scan_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int DIGIT_HZ       = 1000,
  parameter int NUM_DIGITS     = NUM_DIGITS_DEF,
  parameter int GUARD_CYC      = 50,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst,
  stopwatch_fnd_scan_if.slave fnd
);

  localparam int DWELL = CLK_HZ / DIGIT_HZ;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // The frame snapshot is taken on guard cycle 0, so at least one guard cycle is required.
  generate
    if (DWELL < GUARD_CYC + 2 || NUM_DIGITS < 1 || GUARD_CYC < 1) begin : g_param_err
      $error("stopwatch_fnd_scan: need DWELL >= GUARD_CYC+2, GUARD_CYC >= 1, NUM_DIGITS >= 1");
    end
  endgenerate

  function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(
    input logic [4*NUM_DIGITS-1:0] d,
    input logic [NUM_DIGITS-1:0]   dpm
  );
    logic run;
    lz_blank_mask = '0;
    run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run = run && (d[4*k +: 4] == 4'd0) && !dpm[k];
      lz_blank_mask[k] = run;
    end
  endfunction

  function automatic logic [7:0] seg_pol(input logic [7:0] x);
    return SEG_ACTIVE_LOW ? ~x : x;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] com_pol(input logic [NUM_DIGITS-1:0] x);
    return COM_ACTIVE_LOW ? ~x : x;
  endfunction

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  scan_state_t             state, state_nxt;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    slot_end, frame_start;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic [7:0]              seg_hi;
  logic                    show;
  logic [NUM_DIGITS-1:0]   com_nxt, com_q;
  logic [7:0]              seg_nxt, seg_q;
  logic                    fs_q;

  assign slot_end    = (cnt == CNT_LAST);
  assign frame_start = (cnt == '0) && (idx == '0);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) state <= S_GUARD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_GUARD: if (cnt == GUARD_LAST) state_nxt = S_ON;
      S_ON:    if (slot_end)          state_nxt = S_GUARD;
      default:                        state_nxt = S_GUARD;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      snap_digits <= '0;
      snap_dp     <= '0;
    end else if (frame_start) begin
      snap_digits <= fnd.iDigits;
      snap_dp     <= fnd.iDpMask;
    end
  end

  assign lz_mask = LZ_BLANK ? lz_blank_mask(snap_digits, snap_dp) : '0;
  assign cur_nib = snap_digits[4*idx +: 4];
  assign cur_dp  = snap_dp[idx];

  stopwatch_fnd_scan_decode u_decode (
    .nib (cur_nib),
    .dp  (cur_dp),
    .seg (seg_hi)
  );

  always_comb begin
    show    = (state == S_ON) && !fnd.iBlank && !lz_mask[idx];
    com_nxt = com_pol('0);
    seg_nxt = seg_pol('0);
    if (show) begin
      com_nxt = com_pol(NUM_DIGITS'(1) << idx);
      seg_nxt = seg_pol(seg_hi);
    end
  end

  // Pin registers: one cycle behind cnt/idx
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      com_q <= com_pol('0);
      seg_q <= seg_pol('0);
      fs_q  <= 1'b0;
    end else begin
      com_q <= com_nxt;
      seg_q <= seg_nxt;
      fs_q  <= frame_start;
    end
  end

  assign fnd.oCom        = com_q;
  assign fnd.oSeg        = seg_q;
  assign fnd.oFrameStart = fs_q;

endmodule
